// File: rtl/mscell_pkg.sv
// Shared definitions for the metastable-cell TRNG controller: state encoding,
// default parameter values and small arithmetic helpers.
package mscell_pkg;

   localparam int SETTLE_CYCLES_DEF = 4;
   localparam int WORD_W_DEF        = 8;
   localparam int REP_LIMIT_DEF     = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRE    = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CAP    = 3'd3,
      ST_SYNC   = 3'd4,
      ST_HOLD   = 3'd5,
      ST_FAIL   = 3'd6
   } state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

   // Precharge direction: {in1, in0}; polarity 0 precharges towards 0.
   function automatic logic [1:0] pre_enables(input logic pol);
      return {pol, ~pol};
   endfunction

endpackage

// File: rtl/mscell_rct.sv
// Repetition-count health test: tracks the run length of identical bits and
// raises a sticky failure once the run reaches REP_LIMIT.
module mscell_rct
   import mscell_pkg::*;
#(
   parameter int REP_LIMIT = REP_LIMIT_DEF
) (
   input  logic clk_sampling,
   input  logic rst,
   input  logic bit_i,
   input  logic bit_strobe_i,
   output logic health_fail_o
);

   logic       last_q, last_d;
   logic [7:0] run_q, run_d;
   logic       fail_q, fail_d;
   logic       trip_s;

   // Run-length update on each new bit; output includes a trip in this cycle
   // so the controller can stop before issuing another enable.
   always_comb begin
      last_d = last_q;
      run_d  = run_q;
      trip_s = 1'b0;
      if (bit_strobe_i) begin
         last_d = bit_i;
         if ((run_q != 8'd0) && (bit_i == last_q)) begin
            run_d = sat_inc8(run_q);
         end else begin
            run_d = 8'd1;
         end
         if (run_d >= 8'(REP_LIMIT)) begin
            trip_s = 1'b1;
         end else begin
            trip_s = 1'b0;
         end
      end else begin
         trip_s = 1'b0;
      end
      fail_d = fail_q | trip_s;
   end

   // Run-length and sticky flag registers.
   always_ff @(posedge clk_sampling) begin
      if (rst) begin
         last_q <= 1'b0;
         run_q  <= 8'd0;
         fail_q <= 1'b0;
      end else begin
         last_q <= last_d;
         run_q  <= run_d;
         fail_q <= fail_d;
      end
   end

   assign health_fail_o = fail_d;

endmodule

// File: rtl/mscell_ctrl.sv
// Metastable-cell TRNG controller: sequences precharge/settle/capture of the
// cell, synchronizes its output, packs bits into words and hands them out.
module mscell_ctrl
   import mscell_pkg::*;
#(
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int WORD_W        = WORD_W_DEF,
   parameter int REP_LIMIT     = REP_LIMIT_DEF
) (
   input  logic              clk_sampling,
   input  logic              rst,
   input  logic              start,
   input  logic              Y,
   output logic              en_Samp_in0,
   output logic              en_Samp_in1,
   output logic              en_Samp_out,
   output logic [WORD_W-1:0] rnd_data,
   output logic              rnd_valid,
   input  logic              rnd_ready,
   output logic              health_fail
);

   localparam int CW = $clog2(WORD_W + 1);

   state_e            state_q, state_d;
   logic [7:0]        tmr_q, tmr_d;
   logic              pol_q, pol_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              in0_q, in0_d;
   logic              in1_q, in1_d;
   logic              out_q, out_d;
   logic              hfail_q, hfail_d;
   logic              sync1_q, sync2_q;
   logic              strobe_s;
   logic              rct_fail_s;
   logic [WORD_W-1:0] shreg_shift_s;
   logic [1:0]        pre_en_s;

   // Two-flop synchronizer for the asynchronous cell output.
   always_ff @(posedge clk_sampling) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= Y;
         sync2_q <= sync1_q;
      end
   end

   assign shreg_shift_s = {shreg_q[WORD_W-2:0], sync2_q};
   assign strobe_s      = (state_q == ST_SYNC) && (tmr_q == 8'd1);

   mscell_rct #(
      .REP_LIMIT(REP_LIMIT)
   ) u_rct (
      .clk_sampling (clk_sampling),
      .rst          (rst),
      .bit_i        (sync2_q),
      .bit_strobe_i (strobe_s),
      .health_fail_o(rct_fail_s)
   );

   // Next-state logic for the bit sequencer, word packer and output handshake.
   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      pol_d    = pol_q;
      cnt_d    = cnt_q;
      shreg_d  = shreg_q;
      data_d   = data_q;
      valid_d  = valid_q & ~rnd_ready;
      case (state_q)
         ST_IDLE: begin
            if (start && !hfail_q) begin
               state_d = ST_PRE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRE: begin
            state_d = ST_SETTLE;
            tmr_d   = 8'd0;
         end
         ST_SETTLE: begin
            if (tmr_q == 8'(SETTLE_CYCLES - 1)) begin
               state_d = ST_CAP;
               tmr_d   = 8'd0;
            end else begin
               tmr_d   = tmr_q + 8'd1;
            end
         end
         ST_CAP: begin
            state_d = ST_SYNC;
            tmr_d   = 8'd0;
         end
         ST_SYNC: begin
            if (tmr_q == 8'd0) begin
               tmr_d = 8'd1;
            end else begin
               shreg_d = shreg_shift_s;
               pol_d   = ~pol_q;
               // A health trip discards whatever word this bit would complete.
               if (rct_fail_s) begin
                  state_d = ST_FAIL;
                  valid_d = 1'b0;
                  cnt_d   = '0;
               end else if (cnt_q == CW'(WORD_W - 1)) begin
                  if (!valid_q || rnd_ready) begin
                     data_d  = shreg_shift_s;
                     valid_d = 1'b1;
                     cnt_d   = '0;
                     if (start) begin
                        state_d = ST_PRE;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else begin
                     cnt_d   = CW'(WORD_W);
                     state_d = ST_HOLD;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  if (start) begin
                     state_d = ST_PRE;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (rnd_ready) begin
               data_d  = shreg_q;
               valid_d = 1'b1;
               cnt_d   = '0;
               if (start) begin
                  state_d = ST_PRE;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_FAIL: begin
            state_d = ST_FAIL;
            valid_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase

      pre_en_s = pre_enables(pol_d);
      if (state_d == ST_PRE) begin
         in0_d = pre_en_s[0];
         in1_d = pre_en_s[1];
      end else begin
         in0_d = 1'b0;
         in1_d = 1'b0;
      end
      out_d   = (state_d == ST_CAP);
      hfail_d = rct_fail_s;
   end

   // State and registered outputs.
   always_ff @(posedge clk_sampling) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tmr_q   <= 8'd0;
         pol_q   <= 1'b0;
         cnt_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         in0_q   <= 1'b0;
         in1_q   <= 1'b0;
         out_q   <= 1'b0;
         hfail_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         pol_q   <= pol_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         in0_q   <= in0_d;
         in1_q   <= in1_d;
         out_q   <= out_d;
         hfail_q <= hfail_d;
      end
   end

   assign en_Samp_in0 = in0_q;
   assign en_Samp_in1 = in1_q;
   assign en_Samp_out = out_q;
   assign rnd_data    = data_q;
   assign rnd_valid   = valid_q;
   assign health_fail = hfail_q;

endmodule

// File: tb/tb_mscell_ctrl.sv
// Self-checking bench for mscell_ctrl: a bit-period/word-level reference model
// is compared with the DUT every cycle, plus hand-computed timing checks.
module tb_mscell_ctrl;

   localparam int SC = 4;
   localparam int W  = 8;
   localparam int RL = 32;
   localparam int P  = SC + 4;

   logic clk_sampling = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic Y = 1'b0;
   logic rnd_ready = 1'b0;
   logic en_Samp_in0, en_Samp_in1, en_Samp_out, rnd_valid, health_fail;
   logic [W-1:0] rnd_data;

   mscell_ctrl #(
      .SETTLE_CYCLES(SC),
      .WORD_W       (W),
      .REP_LIMIT    (RL)
   ) dut (
      .clk_sampling(clk_sampling),
      .rst         (rst),
      .start       (start),
      .Y           (Y),
      .en_Samp_in0 (en_Samp_in0),
      .en_Samp_in1 (en_Samp_in1),
      .en_Samp_out (en_Samp_out),
      .rnd_data    (rnd_data),
      .rnd_valid   (rnd_valid),
      .rnd_ready   (rnd_ready),
      .health_fail (health_fail)
   );

   always #5 clk_sampling = ~clk_sampling;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: mode 0 idle, 1 generating (phase 0 = precharge), 2 word waiting, 3 failed.
   int       m_mode = 0;
   int       m_phase = 0;
   int       m_run = 0;
   bit       m_pol = 1'b0, m_last = 1'b0, m_valid = 1'b0, m_hfail = 1'b0;
   bit       m_ycur = 1'b0, m_nv = 1'b0;
   logic [W-1:0] m_data = '0;
   bit       m_q[$];
   int       y_mode = 0;
   bit       y_tog = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_next_bit();
      m_phase = 0;
      if (start) m_mode = 1;
      else       m_mode = 0;
   endtask

   task automatic model_deliver();
      for (int i = 0; i < W; i++) m_data[W-1-i] = m_q[i];
      m_q.delete();
      m_nv = 1'b1;
      model_next_bit();
   endtask

   task automatic model_step();
      if (rst) begin
         m_mode = 0; m_phase = 0; m_run = 0;
         m_pol = 1'b0; m_last = 1'b0; m_valid = 1'b0; m_hfail = 1'b0;
         m_data = '0;
         m_q.delete();
      end else begin
         m_nv = m_valid && !rnd_ready;
         case (m_mode)
            0: begin
               if (start && !m_hfail) begin
                  m_mode = 1; m_phase = 0;
               end
            end
            1: begin
               if (m_phase < P - 1) begin
                  m_phase++;
               end else begin
                  m_pol = !m_pol;
                  if (m_run > 0 && m_ycur == m_last) m_run++;
                  else m_run = 1;
                  m_last = m_ycur;
                  m_q.push_back(m_ycur);
                  if (m_run >= RL) begin
                     m_hfail = 1'b1; m_mode = 3; m_nv = 1'b0; m_q.delete();
                  end else if (m_q.size() == W) begin
                     if (!m_valid || rnd_ready) model_deliver();
                     else m_mode = 2;
                  end else begin
                     model_next_bit();
                  end
               end
            end
            2: if (rnd_ready) model_deliver();
            3: m_nv = 1'b0;
            default: m_mode = 0;
         endcase
         m_valid = m_nv;
      end
   endtask

   task automatic compare_now();
      logic e0, e1, eo;
      e0 = (m_mode == 1) && (m_phase == 0) && !m_pol;
      e1 = (m_mode == 1) && (m_phase == 0) && m_pol;
      eo = (m_mode == 1) && (m_phase == SC + 1);
      check("outs{in0,in1,out,valid,hf}",
            32'({en_Samp_in0, en_Samp_in1, en_Samp_out, rnd_valid, health_fail}),
            32'({e0, e1, eo, m_valid, m_hfail}));
      if (m_valid) check("data", 32'(rnd_data), 32'(m_data));
   endtask

   // Advance one cycle: predict, pick the cell value for a new bit, sample at negedge.
   task automatic step();
      model_step();
      if (!rst && m_mode == 1 && m_phase == 0) begin
         case (y_mode)
            0: m_ycur = 1'($urandom_range(0, 1));
            1: begin m_ycur = y_tog; y_tog = !y_tog; end
            default: m_ycur = 1'b1;
         endcase
         Y = m_ycur;
      end
      @(negedge clk_sampling);
      cyc++;
      compare_now();
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; rnd_ready = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   initial begin
      int t_pre, t_pre2, t_out, t_valid, t_hf, found, viol, saw_cap, saw_pre;
      logic first_in1, second_in1;
      logic [W-1:0] d0, held;

      // Reset state
      do_reset();
      check("reset_outs", 32'({en_Samp_in0, en_Samp_in1, en_Samp_out, rnd_valid, health_fail}), 32'd0);
      check("reset_data", 32'(rnd_data), 32'd0);

      // Alternating cell output: enable timing and first word
      y_mode = 1; y_tog = 1'b0; start = 1'b1; rnd_ready = 1'b1;
      t_pre = -1; t_pre2 = -1; t_out = -1; t_valid = -1;
      first_in1 = 1'b1; second_in1 = 1'b0; d0 = '0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (en_Samp_in0 | en_Samp_in1) begin
            if (t_pre < 0) begin t_pre = cyc; first_in1 = en_Samp_in1; end
            else if (t_pre2 < 0) begin t_pre2 = cyc; second_in1 = en_Samp_in1; end
         end
         if (en_Samp_out && t_out < 0) t_out = cyc;
         if (rnd_valid && t_valid < 0) begin t_valid = cyc; d0 = rnd_data; end
      end
      check("pre_to_cap", 32'(t_out - t_pre), 32'd5);
      check("bit_period", 32'(t_pre2 - t_pre), 32'd8);
      check("first_pre_in1", 32'(first_in1), 32'd0);
      check("second_pre_in1", 32'(second_in1), 32'd1);
      check("first_word_latency", 32'(t_valid - t_pre), 32'd64);
      check("first_word", 32'(d0), 32'h55);

      // Random traffic with random back-pressure and start toggling
      do_reset();
      y_mode = 0; start = 1'b1;
      for (int i = 0; i < 900; i++) begin
         rnd_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 59) == 0) start = !start;
         step();
      end

      // Consumer stalled: word held, no enables, then release
      do_reset();
      y_mode = 0; start = 1'b1; rnd_ready = 1'b0;
      repeat (300) step();
      viol = 0; held = rnd_data;
      repeat (10) begin
         step();
         if (en_Samp_in0 | en_Samp_in1 | en_Samp_out | !rnd_valid | (rnd_data !== held)) viol++;
      end
      check("hold_quiet", 32'(viol), 32'd0);
      rnd_ready = 1'b1;
      step();
      check("hold_release_valid", 32'(rnd_valid), 32'd1);
      repeat (150) step();
      rnd_ready = 1'b0;
      repeat (300) step();
      rst = 1'b1; step(); rst = 1'b0;
      check("rst_in_hold", 32'({en_Samp_in0, en_Samp_in1, en_Samp_out, rnd_valid, health_fail, rnd_data}), 32'd0);

      // Reset during capture
      do_reset();
      y_mode = 0; start = 1'b1; rnd_ready = 1'b1;
      repeat (13) step();
      found = 0;
      for (int i = 0; i < 50 && found == 0; i++) begin
         step();
         if (en_Samp_out) found = 1;
      end
      check("cap_seen", 32'(found), 32'd1);
      rst = 1'b1; step(); rst = 1'b0;
      check("rst_in_cap", 32'({en_Samp_in0, en_Samp_in1, en_Samp_out, rnd_valid, health_fail, rnd_data}), 32'd0);

      // start dropped during settle: bit completes, then idle; resume keeps count
      do_reset();
      y_mode = 1; y_tog = 1'b0; start = 1'b1; rnd_ready = 1'b1;
      repeat (20) step();
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         step();
         if (en_Samp_in0 | en_Samp_in1) found = 1;
      end
      check("drop_pre_seen", 32'(found), 32'd1);
      step();
      start = 1'b0; saw_cap = 0; saw_pre = 0;
      repeat (30) begin
         step();
         if (en_Samp_out) saw_cap++;
         if (en_Samp_in0 | en_Samp_in1) saw_pre++;
      end
      check("drop_cap_completes", 32'(saw_cap), 32'd1);
      check("drop_no_new_pre", 32'(saw_pre), 32'd0);
      start = 1'b1;
      repeat (150) step();

      // Stuck cell output: health failure on the 32nd identical bit
      do_reset();
      y_mode = 2; start = 1'b1; rnd_ready = 1'b1;
      t_pre = -1; t_hf = -1;
      for (int i = 0; i < 400 && t_hf < 0; i++) begin
         step();
         if (t_pre < 0 && (en_Samp_in0 | en_Samp_in1)) t_pre = cyc;
         if (health_fail) t_hf = cyc;
      end
      check("hf_latency", 32'(t_hf - t_pre), 32'd256);
      viol = 0;
      repeat (40) begin
         step();
         if (en_Samp_in0 | en_Samp_in1 | en_Samp_out | rnd_valid | !health_fail) viol++;
      end
      check("fail_quiet", 32'(viol), 32'd0);
      rst = 1'b1; step(); rst = 1'b0;
      check("hf_cleared", 32'(health_fail), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
